// File: rtl/ir_history_if.sv
// ir_history_if -- bundle of the control, write and read signals of ir_history.
//
// Parameters:
//   WIDTH : bit width of each recorded instruction word
//   DEPTH : number of history entries (power of two, >= 2)
//   AW    : width of the read index
//
// Signals (direction seen from the master, i.e. the block feeding the history):
//   push     out  a retired instruction is presented on din this cycle
//   din      out  instruction word to record
//   trigger  out  exception/interrupt event, freezes the history
//   resume   out  leave the frozen state
//   clear    out  flush all entries and flags
//   rd_idx   out  read age, 0 = newest
//   rd_data  in   entry at age rd_idx (combinational), 0 when not valid
//   rd_valid in   rd_idx < count
//   count    in   number of valid entries, 0..DEPTH
//   frozen   in   history is frozen
//   overflow in   sticky: at least one entry was lost by wrap-around
interface ir_history_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic             push;
  logic [WIDTH-1:0] din;
  logic             trigger;
  logic             resume;
  logic             clear;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [AW:0]      count;
  logic             frozen;
  logic             overflow;

  modport master (
    output push, din, trigger, resume, clear, rd_idx,
    input  rd_data, rd_valid, count, frozen, overflow
  );

  modport slave (
    input  push, din, trigger, resume, clear, rd_idx,
    output rd_data, rd_valid, count, frozen, overflow
  );
endinterface

// File: rtl/ir_history.sv
// ir_history -- instruction retirement history buffer.
//
// Records the last DEPTH retired instruction words in a circular buffer.
// An exception/interrupt trigger freezes the history so software or a debug
// port can inspect what led up to the event; resume re-arms recording.
//
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   reset  : synchronous, active-high; outputs read as empty while asserted
//   bus    : ir_history_if slave modport (push/din/trigger/resume/clear in,
//            age-indexed combinational read port and status flags out)
//
// Control priority at each edge: reset > clear > trigger > resume > push.
// A push together with trigger in RUN is still recorded before freezing.
module ir_history #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  ir_history_if.slave  bus
);

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  state_t           state_reg;
  logic [AW-1:0]    wp_reg;        // next slot to be written
  logic [AW:0]      count_reg;
  logic             overflow_reg;

  // History storage; deliberately not reset, every read is masked by count.
  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid_int;

  // A push only lands while running and when no higher-priority flush is in
  // this cycle. Trigger does not block it: the triggering instruction must be
  // the newest entry of the frozen history.
  assign accept = !reset && !bus.clear && (state_reg == ST_RUN) && bus.push;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wp_reg] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state_reg    <= ST_RUN;
      wp_reg       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.push) begin
            wp_reg <= wp_reg + PTR_ONE;
            if (count_reg == FULL) begin
              // Oldest entry is overwritten in place; remember the loss.
              overflow_reg <= 1'b1;
            end else begin
              count_reg <= count_reg + CNT_ONE;
            end
          end
          if (bus.trigger) begin
            state_reg <= ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          // Trigger keeps the freeze even when resume is also high; a push in
          // the resume cycle is dropped because we are still frozen here.
          if (!bus.trigger && bus.resume) begin
            state_reg <= ST_RUN;
          end
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // Age 0 is the slot just behind the write pointer; the AW-bit subtraction
  // wraps naturally because DEPTH is a power of two.
  assign rd_addr      = wp_reg - PTR_ONE - bus.rd_idx;
  assign rd_valid_int = ({1'b0, bus.rd_idx} < count_reg);

  // Outputs are forced to the empty view while reset is held, so nothing
  // observable depends on pre-reset register contents.
  always_comb begin
    bus.count    = '0;
    bus.frozen   = 1'b0;
    bus.overflow = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data  = '0;
    if (!reset) begin
      bus.count    = count_reg;
      bus.frozen   = (state_reg == ST_FROZEN);
      bus.overflow = overflow_reg;
      bus.rd_valid = rd_valid_int;
      if (rd_valid_int) begin
        bus.rd_data = mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_ir_history.sv
// tb_ir_history -- self-checking bench for ir_history (WIDTH=32, DEPTH=4).
//
// A queue-based model (newest word at the front) tracks what the history
// should hold; a negedge process compares every DUT output to it each cycle.
// Directed sequences add literal expectations for the key scenarios, then a
// long randomized run exercises all control combinations.
module tb_ir_history;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk;
  logic reset;

  ir_history_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  ir_history #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model
  logic [WIDTH-1:0] hist[$];
  bit               m_frozen = 1'b0;
  bit               m_ovf    = 1'b0;
  bit               chk_en   = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit c, input bit p,
                              input bit t, input bit rs, input logic [WIDTH-1:0] d);
    if (r || c) begin
      hist.delete();
      m_frozen = 1'b0;
      m_ovf    = 1'b0;
    end else if (!m_frozen) begin
      if (p) begin
        hist.push_front(d);
        if (hist.size() > DEPTH) begin
          void'(hist.pop_back());
          m_ovf = 1'b1;
        end
      end
      if (t) m_frozen = 1'b1;
    end else if (!t && rs) begin
      m_frozen = 1'b0;
    end
  endtask

  // One clock cycle: drive controls, let the edge happen, update the model,
  // release the controls, and return early in the low phase.
  task automatic step(input bit r, input bit c, input bit p, input bit t,
                      input bit rs, input logic [WIDTH-1:0] d);
    reset       = r;
    bus.clear   = c;
    bus.push    = p;
    bus.trigger = t;
    bus.resume  = rs;
    bus.din     = d;
    @(posedge clk);
    model_update(r, c, p, t, rs, d);
    #1;
    reset       = 1'b0;
    bus.clear   = 1'b0;
    bus.push    = 1'b0;
    bus.trigger = 1'b0;
    bus.resume  = 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic push_w(input logic [WIDTH-1:0] d);
    step(0, 0, 1, 0, 0, d);
  endtask

  task automatic rd(input string name, input int k, input logic [WIDTH-1:0] exp_d,
                    input bit exp_v);
    bus.rd_idx = AW'(k);
    #1;
    check({name, ".valid"}, {31'd0, bus.rd_valid}, {31'd0, exp_v});
    check({name, ".data"}, bus.rd_data, exp_d);
  endtask

  // Per-cycle comparison against the model
  logic [WIDTH-1:0] e_data;
  logic [AW:0]      e_cnt;
  bit               e_valid;
  always @(negedge clk) begin
    if (chk_en) begin
      e_cnt   = reset ? '0 : (AW+1)'(hist.size());
      e_valid = !reset && (int'(bus.rd_idx) < hist.size());
      e_data  = e_valid ? hist[bus.rd_idx] : '0;
      check("cyc.count", {29'd0, bus.count}, {29'd0, e_cnt});
      check("cyc.frozen", {31'd0, bus.frozen}, {31'd0, !reset && m_frozen});
      check("cyc.overflow", {31'd0, bus.overflow}, {31'd0, !reset && m_ovf});
      check("cyc.rd_valid", {31'd0, bus.rd_valid}, {31'd0, e_valid});
      check("cyc.rd_data", bus.rd_data, e_data);
    end
  end

  initial begin
    reset       = 1'b1;
    bus.clear   = 1'b0;
    bus.push    = 1'b0;
    bus.trigger = 1'b0;
    bus.resume  = 1'b0;
    bus.din     = '0;
    bus.rd_idx  = '0;
    #2;
    // Outputs must already read empty while reset is held, before any edge.
    check("rst.count", {29'd0, bus.count}, 32'd0);
    check("rst.frozen", {31'd0, bus.frozen}, 32'd0);
    check("rst.overflow", {31'd0, bus.overflow}, 32'd0);
    rd("rst.rd", 0, 32'd0, 1'b0);
    step(1, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, '0);
    chk_en = 1'b1;

    // Basic fill
    push_w(32'h11); push_w(32'h22); push_w(32'h33);
    check("fill.count", {29'd0, bus.count}, 32'd3);
    rd("fill.age0", 0, 32'h33, 1'b1);
    rd("fill.age2", 2, 32'h11, 1'b1);
    rd("fill.age3", 3, 32'h0, 1'b0);
    check("fill.overflow", {31'd0, bus.overflow}, 32'd0);

    // Wrap-around
    step(1, 0, 0, 0, 0, '0);
    for (int i = 1; i <= 6; i++) push_w(WIDTH'(i));
    check("wrap.count", {29'd0, bus.count}, 32'd4);
    rd("wrap.age0", 0, 32'h06, 1'b1);
    rd("wrap.age1", 1, 32'h05, 1'b1);
    rd("wrap.age2", 2, 32'h04, 1'b1);
    rd("wrap.age3", 3, 32'h03, 1'b1);
    check("wrap.overflow", {31'd0, bus.overflow}, 32'd1);

    // Freeze with push
    step(1, 0, 0, 0, 0, '0);
    push_w(32'hA1);
    step(0, 0, 1, 1, 0, 32'hA2);
    push_w(32'hA3); push_w(32'hA4);
    check("frz.frozen", {31'd0, bus.frozen}, 32'd1);
    check("frz.count", {29'd0, bus.count}, 32'd2);
    rd("frz.age0", 0, 32'hA2, 1'b1);
    rd("frz.age1", 1, 32'hA1, 1'b1);

    // Resume with push
    step(0, 0, 1, 0, 1, 32'hB0);
    push_w(32'hB1);
    check("res.frozen", {31'd0, bus.frozen}, 32'd0);
    check("res.count", {29'd0, bus.count}, 32'd3);
    rd("res.age0", 0, 32'hB1, 1'b1);
    rd("res.age1", 1, 32'hA2, 1'b1);

    // Clear priority from full with overflow
    push_w(32'hC1); push_w(32'hC2);
    check("clr.pre_overflow", {31'd0, bus.overflow}, 32'd1);
    step(0, 1, 1, 1, 0, 32'hFF);
    check("clr.count", {29'd0, bus.count}, 32'd0);
    check("clr.overflow", {31'd0, bus.overflow}, 32'd0);
    check("clr.frozen", {31'd0, bus.frozen}, 32'd0);
    rd("clr.rd", 0, 32'h0, 1'b0);

    // Reset in the middle of a freeze
    for (int i = 0; i < 4; i++) push_w(32'h50 + WIDTH'(i));
    step(0, 0, 0, 1, 0, '0);
    check("rstf.pre_frozen", {31'd0, bus.frozen}, 32'd1);
    step(1, 0, 1, 0, 0, 32'h77);
    check("rstf.count", {29'd0, bus.count}, 32'd0);
    check("rstf.frozen", {31'd0, bus.frozen}, 32'd0);
    push_w(32'h88);
    check("rstf.count1", {29'd0, bus.count}, 32'd1);
    rd("rstf.age0", 0, 32'h88, 1'b1);

    // Randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      bit r, c, p, t, rs;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 59) == 0);
      p  = ($urandom_range(0, 9) < 7);
      t  = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 9) == 0);
      bus.rd_idx = AW'($urandom_range(0, DEPTH - 1));
      step(r, c, p, t, rs, $urandom);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/ir_history.md
IR_HISTORY -- requirements
Module: ir_history

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each recorded instruction word.
REQ-002 Parameter DEPTH, default 8: number of history entries; power of two, at least 2.
REQ-003 Parameter AW, default $clog2(DEPTH): width of the read index.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 push  input  1: a retired instruction is presented on din this cycle.
REQ-007 din  input  WIDTH: instruction word to record, for example IR at writeback.
REQ-008 trigger  input  1: exception/interrupt event; freezes the history.
REQ-009 resume  input  1: leave frozen state.
REQ-010 clear  input  1: flush all entries and flags.
REQ-011 rd_idx  input  AW: read age; 0 is the newest entry, DEPTH-1 the oldest.
REQ-012 rd_data  output  WIDTH: entry at age rd_idx (combinational).
REQ-013 rd_valid  output  1: rd_idx < count.
REQ-014 count  output  AW+1: number of valid entries, 0..DEPTH.
REQ-015 frozen  output  1: high in state FROZEN.
REQ-016 overflow  output  1: sticky flag; at least one entry was discarded by wrap-around.

Function
REQ-017 Storage: circular buffer of DEPTH words, a write pointer wp (AW bits, wraps DEPTH-1->0), and count.
REQ-018 State machine states:
- RUN: pushes are accepted.
- FROZEN: pushes are ignored; storage, wp, count and overflow hold.
REQ-019 Accepted push in RUN: mem[wp] <= din; wp <= wp+1 mod DEPTH; count <= min(count+1, DEPTH).
REQ-020 Latency: a word pushed at edge t reads at rd_idx=0 from edge t onward (1-cycle write, combinational read).
REQ-021 Ordering: after each accepted push, the previous age-k entry becomes the age-(k+1) entry.
REQ-022 Read address: rd_data = mem[(wp-1-rd_idx) mod DEPTH] when rd_valid=1; otherwise rd_data = 0.
REQ-023 Full case: a push in RUN with count==DEPTH overwrites the oldest entry, count stays DEPTH, and overflow <= 1.
REQ-024 Transition RUN->FROZEN on trigger=1.
REQ-025 Simultaneous trigger and push in RUN: the push is recorded first, then the block freezes. That word is age 0 while frozen.
REQ-026 Transition FROZEN->RUN on resume=1 with trigger=0.
REQ-027 A push in the same cycle as resume is ignored; pushes are accepted from the next cycle.
REQ-028 trigger=1 in FROZEN keeps FROZEN, and takes priority over resume.
REQ-029 resume=1 in RUN has no effect.
REQ-030 clear=1 in any state: count<=0, wp<=0, overflow<=0, state<=RUN. Storage contents need not be zeroed; rd_data still reads 0 because rd_valid=0.
REQ-031 clear overrides push, trigger and resume in the same cycle.
REQ-032 Read port is usable in both states and has no side effects.
REQ-033 Priority order: reset > clear > trigger > resume > push.

Reset
REQ-034 reset=1 at a rising edge sets state=RUN, wp=0, count=0, overflow=0.
REQ-035 While reset is asserted, the outputs read frozen=0, count=0, rd_valid=0, rd_data=0, overflow=0.
REQ-036 Reset asserted mid-operation (RUN or FROZEN) discards all history at that edge; inputs are ignored in that cycle.
REQ-037 Storage needs no reset; no output may depend on unwritten storage.

Verification (WIDTH=32, DEPTH=4)
REQ-038 Basic fill:
- Stimulus: after reset, push 0x11, 0x22, 0x33 on consecutive cycles.
- Required: count=3; rd_idx=0 reads 0x33; rd_idx=2 reads 0x11; rd_idx=3 gives rd_valid=0 and rd_data=0; overflow=0.
REQ-039 Wrap-around:
- Stimulus: push 0x01 through 0x06.
- Required: count=4; ages 0..3 read 0x06, 0x05, 0x04, 0x03; overflow=1.
REQ-040 Freeze with push:
- Stimulus: push 0xA1, then push 0xA2 with trigger=1, then push 0xA3 and 0xA4.
- Required: frozen=1; age 0 reads 0xA2; age 1 reads 0xA1; count=2.
REQ-041 Resume with push:
- Stimulus: from REQ-040, resume=1 with push 0xB0, then push 0xB1.
- Required: frozen=0; age 0 reads 0xB1; age 1 reads 0xA2; count=3.
REQ-042 Clear priority:
- Stimulus: while full with overflow=1, clear=1 together with push 0xFF and trigger=1.
- Required: next cycle count=0, overflow=0, frozen=0, rd_valid=0.
REQ-043 Reset mid-freeze:
- Stimulus: in FROZEN with count=4, reset=1 for one cycle together with push 0x77.
- Required: count=0 and frozen=0. The next push 0x88 gives count=1 and age 0 reads 0x88.
